// File: rtl/mac_table_pkg.sv
// Shared widths, table entry layout and controller states for the MAC learn table.
package mac_table_pkg;

  localparam int unsigned KEY_W   = 48;
  localparam int unsigned IDX_W   = 12;
  localparam int unsigned PORT_W  = 4;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned DEPTH   = 1 << IDX_W;

  typedef struct packed {
    logic              valid;
    logic [KEY_W-1:0]  key;
    logic [PORT_W-1:0] port;
  } mac_entry_t;

  localparam int unsigned ENTRY_W = $bits(mac_entry_t);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    LOOKUP,
    RESP
  } mac_state_e;

endpackage

// File: rtl/mac_table_ram.sv
// Single-port table storage: registered read, read-before-write, no reset.
module mac_table_ram
  import mac_table_pkg::*;
(
  input  logic               clk,
  input  logic [IDX_W-1:0]   addr,
  input  logic               we,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mac_learn_table.sv
// Direct-mapped MAC table: clears itself after reset, then serves one learn or
// lookup at a time through a CLEAR/IDLE/LOOKUP/RESP controller.
module mac_learn_table
  import mac_table_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [KEY_W-1:0]  req_key_i,
  input  logic [IDX_W-1:0]  req_idx_i,
  input  logic [PORT_W-1:0] req_port_i,
  input  logic              req_learn_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_hit_o,
  output logic [PORT_W-1:0] rsp_port_o,
  output logic [CNT_W-1:0]  evict_cnt_o,
  output logic              init_done_o
);

  mac_state_e         state, next_state;
  logic [IDX_W-1:0]   clr_cnt, clr_cnt_d;
  logic [KEY_W-1:0]   lat_key, lat_key_d;
  logic [IDX_W-1:0]   lat_idx, lat_idx_d;
  logic [PORT_W-1:0]  lat_port, lat_port_d;
  logic               lat_learn, lat_learn_d;

  logic               req_ready_d;
  logic               rsp_valid_d;
  logic               rsp_hit_d;
  logic [PORT_W-1:0]  rsp_port_d;
  logic [CNT_W-1:0]   evict_cnt_d;
  logic               init_done_d;

  logic [IDX_W-1:0]   ram_addr;
  logic               ram_we;
  mac_entry_t         ram_wentry;
  logic [ENTRY_W-1:0] ram_rdata;
  mac_entry_t         entry;
  logic               hit;

  mac_table_ram u_ram (
    .clk   (clk_i),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wentry),
    .rdata (ram_rdata)
  );

  assign entry = mac_entry_t'(ram_rdata);
  assign hit   = entry.valid && (entry.key == lat_key);

  // State, request latch and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      lat_key     <= '0;
      lat_idx     <= '0;
      lat_port    <= '0;
      lat_learn   <= 1'b0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_port_o  <= '0;
      evict_cnt_o <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= next_state;
      clr_cnt     <= clr_cnt_d;
      lat_key     <= lat_key_d;
      lat_idx     <= lat_idx_d;
      lat_port    <= lat_port_d;
      lat_learn   <= lat_learn_d;
      req_ready_o <= req_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_hit_o   <= rsp_hit_d;
      rsp_port_o  <= rsp_port_d;
      evict_cnt_o <= evict_cnt_d;
      init_done_o <= init_done_d;
    end
  end

  // Next state, RAM control and next output values
  always_comb begin
    next_state  = state;
    clr_cnt_d   = clr_cnt;
    lat_key_d   = lat_key;
    lat_idx_d   = lat_idx;
    lat_port_d  = lat_port;
    lat_learn_d = lat_learn;
    req_ready_d = 1'b0;
    rsp_valid_d = rsp_valid_o;
    rsp_hit_d   = rsp_hit_o;
    rsp_port_d  = rsp_port_o;
    evict_cnt_d = evict_cnt_o;
    init_done_d = init_done_o;
    ram_addr    = clr_cnt;
    ram_we      = 1'b0;
    ram_wentry  = '0;

    unique case (state)
      CLEAR: begin
        ram_we    = 1'b1;
        clr_cnt_d = clr_cnt + IDX_W'(1);
        if (clr_cnt == '1) begin
          next_state  = IDLE;
          req_ready_d = 1'b1;
          init_done_d = 1'b1;
        end
      end

      IDLE: begin
        req_ready_d = 1'b1;
        ram_addr    = req_idx_i;
        if (req_valid_i && req_ready_o) begin
          lat_key_d   = req_key_i;
          lat_idx_d   = req_idx_i;
          lat_port_d  = req_port_i;
          lat_learn_d = req_learn_i;
          req_ready_d = 1'b0;
          next_state  = LOOKUP;
        end
      end

      LOOKUP: begin
        ram_addr = lat_idx;
        // A learn that matches key and port leaves the entry untouched
        if (lat_learn && !(hit && (entry.port == lat_port))) begin
          ram_we     = 1'b1;
          ram_wentry = '{valid: 1'b1, key: lat_key, port: lat_port};
          if (entry.valid && !hit && (evict_cnt_o != '1)) begin
            evict_cnt_d = evict_cnt_o + CNT_W'(1);
          end
        end
        rsp_valid_d = 1'b1;
        rsp_hit_d   = hit;
        rsp_port_d  = hit ? entry.port : '0;
        next_state  = RESP;
      end

      RESP: begin
        ram_addr = lat_idx;
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          next_state  = IDLE;
        end
      end

      default: next_state = CLEAR;
    endcase
  end

endmodule
